// File: rtl/pulse_burst_scheduler.sv
// Radar burst sequencer: latches a parameter set on cfg_wr, arms against system time,
// then drives tx_gate / rx_blank / pulse strobes. Optional macro PULSE_SCHED_REPEAT_EN repeats the burst.
module pulse_burst_scheduler #(
  parameter int CNT_W = 32,
  parameter int NP_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic             abort,
  input  logic [63:0]      sys_time,
  input  logic [63:0]      time_start,
  input  logic [NP_W-1:0]  n_impulse,
  input  logic [7:0]       type_impulse,
  input  logic [CNT_W-1:0] interval_ti,
  input  logic [CNT_W-1:0] interval_tp,
  input  logic [CNT_W-1:0] tblank1,
  input  logic [CNT_W-1:0] tblank2,
  output logic             tx_gate,
  output logic             rx_blank,
  output logic             pulse_start,
  output logic [7:0]       pulse_type,
  output logic [NP_W-1:0]  pulse_idx,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             late
);

  typedef enum logic [1:0] {IDLE, ARMED, PULSE, GAP} state_t;

`ifdef PULSE_SCHED_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  state_t           state;
  logic [63:0]      sh_start;
  logic [NP_W-1:0]  sh_n;
  logic [7:0]       sh_type;
  logic [CNT_W-1:0] sh_ti;
  logic [CNT_W-1:0] sh_tp;
  logic [CNT_W-1:0] sh_tb1;
  logic [CNT_W-1:0] sh_tb2;
  logic [CNT_W-1:0] cnt;
  logic             first_armed;

  logic             cfg_valid;
  logic             start_now;
  logic             last_pulse;
  logic             more_pulses;
  logic [CNT_W-1:0] gap_len;

  assign cfg_valid   = (n_impulse != '0) && (interval_ti != '0) && (interval_tp > interval_ti);
  assign start_now   = (sh_start == 64'd0) || (sys_time >= sh_start);
  assign last_pulse  = (pulse_idx == sh_n - 1'b1);
  assign more_pulses = REPEAT || !last_pulse;
  assign gap_len     = sh_tp - sh_ti;
  assign busy        = (state != IDLE);

  // Blank ahead of the start time once the remaining distance drops to tblank1.
  function automatic logic pre_blank(input logic [63:0] now, input logic [63:0] ts,
                                     input logic [CNT_W-1:0] tb1);
    return (tb1 != '0) && (now + 64'(tb1) >= ts);
  endfunction

  // c is the gap down-counter value of the cycle being produced: c+1 cycles remain.
  function automatic logic gap_blank(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] glen,
                                     input logic more, input logic [CNT_W-1:0] tb1,
                                     input logic [CNT_W-1:0] tb2);
    logic [CNT_W-1:0] elapsed;
    elapsed = glen - 1'b1 - c;
    return (elapsed < tb2) || (more && (c < tb1));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sh_start    <= '0;
      sh_n        <= '0;
      sh_type     <= '0;
      sh_ti       <= '0;
      sh_tp       <= '0;
      sh_tb1      <= '0;
      sh_tb2      <= '0;
      cnt         <= '0;
      first_armed <= 1'b0;
      tx_gate     <= 1'b0;
      rx_blank    <= 1'b0;
      pulse_start <= 1'b0;
      pulse_type  <= '0;
      pulse_idx   <= '0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      late        <= 1'b0;
    end else begin
      pulse_start <= 1'b0;
      done        <= 1'b0;
      if (cfg_wr) begin
        sh_start <= time_start;
        sh_n     <= n_impulse;
        sh_type  <= type_impulse;
        sh_ti    <= interval_ti;
        sh_tp    <= interval_tp;
        sh_tb1   <= tblank1;
        sh_tb2   <= tblank2;
        tx_gate  <= 1'b0;
        if (cfg_valid) begin
          state       <= ARMED;
          cfg_err     <= 1'b0;
          late        <= 1'b0;
          pulse_idx   <= '0;
          first_armed <= 1'b1;
          rx_blank    <= pre_blank(sys_time, time_start, tblank1);
        end else begin
          state    <= IDLE;
          cfg_err  <= 1'b1;
          rx_blank <= 1'b0;
        end
      end else if (abort) begin
        state    <= IDLE;
        tx_gate  <= 1'b0;
        rx_blank <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tx_gate  <= 1'b0;
            rx_blank <= 1'b0;
          end
          ARMED: begin
            first_armed <= 1'b0;
            if (first_armed && (sh_start != 64'd0) && (sys_time > sh_start))
              late <= 1'b1;
            if (start_now) begin
              state       <= PULSE;
              tx_gate     <= 1'b1;
              rx_blank    <= 1'b1;
              pulse_start <= 1'b1;
              pulse_type  <= sh_type;
              cnt         <= sh_ti - 1'b1;
            end else begin
              rx_blank <= pre_blank(sys_time, sh_start, sh_tb1);
            end
          end
          PULSE: begin
            if (cnt == '0) begin
              state    <= GAP;
              tx_gate  <= 1'b0;
              cnt      <= gap_len - 1'b1;
              rx_blank <= gap_blank(gap_len - 1'b1, gap_len, more_pulses, sh_tb1, sh_tb2);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          GAP: begin
            if (cnt == '0) begin
              if (last_pulse) begin
                done <= 1'b1;
`ifdef PULSE_SCHED_REPEAT_EN
                // Restart on the same Tp grid with the index wrapped.
                pulse_idx   <= '0;
                state       <= PULSE;
                tx_gate     <= 1'b1;
                rx_blank    <= 1'b1;
                pulse_start <= 1'b1;
                pulse_type  <= sh_type;
                cnt         <= sh_ti - 1'b1;
`else
                state    <= IDLE;
                rx_blank <= 1'b0;
`endif
              end else begin
                pulse_idx   <= pulse_idx + 1'b1;
                state       <= PULSE;
                tx_gate     <= 1'b1;
                rx_blank    <= 1'b1;
                pulse_start <= 1'b1;
                pulse_type  <= sh_type;
                cnt         <= sh_ti - 1'b1;
              end
            end else begin
              cnt      <= cnt - 1'b1;
              rx_blank <= gap_blank(cnt - 1'b1, gap_len, more_pulses, sh_tb1, sh_tb2);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Bench for pulse_burst_scheduler: cycle-level model built from burst timing arithmetic
// plus directed scenarios with hand-computed cycle expectations.
module tb_pulse_burst_scheduler;
  localparam int CNT_W = 32;
  localparam int NP_W  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_wr = 1'b0;
  logic             abort = 1'b0;
  logic [63:0]      sys_time = 64'd0;
  logic [63:0]      time_start = 64'd0;
  logic [NP_W-1:0]  n_impulse = '0;
  logic [7:0]       type_impulse = '0;
  logic [CNT_W-1:0] interval_ti = '0;
  logic [CNT_W-1:0] interval_tp = '0;
  logic [CNT_W-1:0] tblank1 = '0;
  logic [CNT_W-1:0] tblank2 = '0;
  logic             tx_gate, rx_blank, pulse_start, busy, done, cfg_err, late;
  logic [7:0]       pulse_type;
  logic [NP_W-1:0]  pulse_idx;

  pulse_burst_scheduler #(.CNT_W(CNT_W), .NP_W(NP_W)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .abort(abort), .sys_time(sys_time),
    .time_start(time_start), .n_impulse(n_impulse), .type_impulse(type_impulse),
    .interval_ti(interval_ti), .interval_tp(interval_tp), .tblank1(tblank1), .tblank2(tblank2),
    .tx_gate(tx_gate), .rx_blank(rx_blank), .pulse_start(pulse_start), .pulse_type(pulse_type),
    .pulse_idx(pulse_idx), .busy(busy), .done(done), .cfg_err(cfg_err), .late(late)
  );

  always #5 clk = ~clk;
  always @(posedge clk) sys_time <= sys_time + 64'd1;

  int errors = 0;
  int checks = 0;

  // Burst model: the burst is described by its first tx cycle and the Tp grid.
  bit     m_act = 0, m_err = 0, m_late = 0;
  longint m_t0, m_ts, m_n, m_ti, m_tp, m_tb1, m_tb2, m_late_from, mk, ma;
  logic [7:0] m_type;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_act = 0; m_err = 0; m_late = 0;
    end else if (cfg_wr) begin
      mk = longint'(sys_time);
      if (n_impulse != 0 && interval_ti != 0 && interval_tp > interval_ti) begin
        m_act = 1; m_err = 0;
        m_ts = longint'(time_start);
        m_n = n_impulse; m_ti = interval_ti; m_tp = interval_tp;
        m_tb1 = tblank1; m_tb2 = tblank2; m_type = type_impulse;
        ma = mk + 1;
        m_t0 = ((m_ts == 0 || m_ts <= ma) ? ma : m_ts) + 1;
        m_late = (m_ts != 0) && (ma > m_ts);
        m_late_from = mk + 2;
      end else begin
        m_act = 0; m_err = 1;
      end
    end else if (abort) begin
      m_act = 0;
    end
  end

  // Observation counters for the directed checks.
  longint tx_total = 0, rx_total = 0, ps_total = 0, done_total = 0;
  longint last_ps = -1, last_done = -1, last_tx_rise = -1, last_rx_rise = -1;
  bit     prev_tx = 0, prev_rx = 0;

  longint ck, off, p, pr, r;
  bit     e_tx, e_rx, e_ps, e_busy, e_done, e_err, e_late, live, more, idx_chk;
  longint e_idx;
  logic [6:0] got_v, exp_v;

  initial forever begin
    @(negedge clk);
    ck = longint'(sys_time);
    e_tx = 0; e_rx = 0; e_ps = 0; e_busy = 0; e_done = 0; idx_chk = 0; e_idx = 0;
    e_err = m_err; e_late = m_late && (ck >= m_late_from);
    if (rst) begin
      e_err = 0; e_late = 0;
    end else if (m_act) begin
      if (ck < m_t0) begin
        e_busy = 1; idx_chk = 1; e_idx = 0;
        e_rx = (m_tb1 != 0) && (ck - 1 + m_tb1 >= m_ts);
      end else begin
        off = ck - m_t0; p = off / m_tp; r = off % m_tp;
`ifdef PULSE_SCHED_REPEAT_EN
        pr = p % m_n; live = 1; more = 1;
        e_done = (r == 0) && (p != 0) && (pr == 0);
`else
        pr = p; live = (p < m_n); more = (p < m_n - 1);
        e_done = (p == m_n) && (r == 0);
`endif
        if (live) begin
          e_busy = 1; idx_chk = 1; e_idx = pr;
          e_tx = (r < m_ti);
          e_ps = (r == 0);
          e_rx = (r < m_ti) || (r - m_ti < m_tb2) || (more && (m_tp - r <= m_tb1));
        end
      end
    end
    got_v = {tx_gate, rx_blank, pulse_start, busy, done, cfg_err, late};
    exp_v = {e_tx, e_rx, e_ps, e_busy, e_done, e_err, e_late};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL cyc=%0d outputs(tx,rx,ps,busy,done,err,late) got=%b required=%b", ck, got_v, exp_v);
    end
    if (idx_chk) begin
      checks++;
      if (longint'(pulse_idx) != e_idx) begin
        errors++;
        $display("FAIL cyc=%0d pulse_idx got=%0d required=%0d", ck, pulse_idx, e_idx);
      end
    end
    if (e_tx) begin
      checks++;
      if (pulse_type !== m_type) begin
        errors++;
        $display("FAIL cyc=%0d pulse_type got=%h required=%h", ck, pulse_type, m_type);
      end
    end
    if (tx_gate) tx_total++;
    if (rx_blank) rx_total++;
    if (pulse_start) begin ps_total++; last_ps = ck; end
    if (done) begin done_total++; last_done = ck; end
    if (tx_gate && !prev_tx) last_tx_rise = ck;
    if (rx_blank && !prev_rx) last_rx_rise = ck;
    prev_tx = tx_gate; prev_rx = rx_blank;
  end

  task automatic chk(input string name, input longint got, input longint req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
    $display("check %s got=%0d required=%0d", name, got, req);
  endtask

  task automatic wait_to(input longint t);
    while (longint'(sys_time) < t) begin
      @(posedge clk); #1;
    end
  endtask

  // rel=1: ts is an offset from sys_time of the cfg_wr cycle.
  task automatic do_cfg(input bit rel, input longint ts, input int n, input int ty, input int ti,
                        input int tp, input int b1, input int b2, output longint c);
    @(posedge clk); #1;
    c = longint'(sys_time);
    time_start   = rel ? 64'(c + ts) : 64'(ts);
    n_impulse    = NP_W'(n);
    type_impulse = 8'(ty);
    interval_ti  = CNT_W'(ti);
    interval_tp  = CNT_W'(tp);
    tblank1      = CNT_W'(b1);
    tblank2      = CNT_W'(b2);
    cfg_wr = 1'b1;
    $display("cfg cyc=%0d ts=%0d n=%0d Ti=%0d Tp=%0d tb1=%0d tb2=%0d", c, time_start, n, ti, tp, b1, b2);
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  longint c, c2, c3, b_tx, b_rx, b_ps, b_done;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_tx", tx_gate, 0);
    rst = 1'b0;
    wait_to(longint'(sys_time) + 2);

    // 1: immediate start, 3 pulses, post-blank 2
    b_tx = tx_total; b_rx = rx_total; b_ps = ps_total; b_done = done_total;
    do_cfg(0, 0, 3, 8'h11, 4, 10, 0, 2, c);
    wait_to(c + 34);
    chk("t1_tx_cycles", tx_total - b_tx, 12);
    chk("t1_rx_cycles", rx_total - b_rx, 18);
    chk("t1_pulses", ps_total - b_ps, 3);
    chk("t1_done_count", done_total - b_done, 1);
    chk("t1_last_ps_cyc", last_ps, c + 22);
    chk("t1_done_cyc", last_done, c + 32);
    chk("t1_busy_after", busy, 0);

    // 2: delayed start with pre-blank 3
    do_cfg(1, 20, 1, 8'h22, 2, 5, 3, 0, c);
    wait_to(c + 28);
    chk("t2_tx_rise", last_tx_rise, c + 21);
    chk("t2_rx_rise", last_rx_rise, c + 18);
    chk("t2_late", late, 0);

    // 3: start time already passed
    do_cfg(1, -5, 2, 8'h33, 2, 4, 0, 0, c);
    wait_to(c + 3);
    chk("t3_first_ps", last_ps, c + 2);
    chk("t3_late", late, 1);
    wait_to(c + 12);

    // 4: invalid sets, then a valid one
    b_tx = tx_total;
    do_cfg(0, 0, 0, 1, 2, 5, 0, 0, c);
    wait_to(c + 4);
    chk("t4_err_n0", cfg_err, 1);
    do_cfg(0, 0, 2, 1, 5, 5, 0, 0, c);
    wait_to(c + 4);
    chk("t4_err_tp_eq_ti", cfg_err, 1);
    do_cfg(0, 0, 2, 1, 0, 5, 0, 0, c);
    wait_to(c + 4);
    chk("t4_err_ti0", cfg_err, 1);
    chk("t4_no_tx", tx_total - b_tx, 0);
    do_cfg(0, 0, 1, 8'h44, 1, 2, 0, 0, c);
    wait_to(c + 2);
    chk("t4_err_cleared", cfg_err, 0);
    wait_to(c + 6);

    // 5: abort during pulse 2 of 4, cfg_wr during a gap, reset mid-pulse
    b_done = done_total;
    do_cfg(0, 0, 4, 8'h55, 3, 8, 1, 1, c);
    wait_to(c + 11);
    abort = 1'b1;
    wait_to(c + 12);
    abort = 1'b0;
    chk("t5_tx_after_abort", tx_gate, 0);
    chk("t5_busy_after_abort", busy, 0);
    wait_to(c + 20);
    do_cfg(0, 0, 3, 8'h66, 2, 6, 0, 0, c2);
    wait_to(c2 + 4);
    do_cfg(0, 0, 3, 8'h67, 2, 6, 0, 0, c3);
    chk("t5_regap_cfg_cyc", c3, c2 + 5);
    wait_to(c3 + 2);
    chk("t5_restart_idx", pulse_idx, 0);
    chk("t5_restart_ps", pulse_start, 1);
    wait_to(c3 + 3);
    rst = 1'b1;
    #1;
    chk("t5_rst_outputs", {tx_gate, rx_blank, pulse_start, busy, done, cfg_err, late, pulse_type, pulse_idx}, 0);
    chk("t5_no_done", done_total - b_done, 0);
    wait_to(c3 + 5);
    rst = 1'b0;
    do_cfg(0, 0, 2, 8'h77, 1, 3, 0, 1, c);
    wait_to(c + 10);

`ifdef PULSE_SCHED_REPEAT_EN
    // 6: repeating burst until abort
    b_done = done_total;
    do_cfg(0, 0, 2, 8'h88, 1, 3, 0, 0, c);
    wait_to(c + 21);
    abort = 1'b1;
    wait_to(c + 22);
    abort = 1'b0;
    chk("t6_done_count", done_total - b_done, 3);
    chk("t6_busy_after_abort", busy, 0);
    wait_to(c + 26);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
